board_clkrst: RTL



---
 rtl/board_pkg.sv | 18 +
 rtl/board_clkrst_debounce.sv | 51 +++++
 rtl/board_clkrst.sv | 113 +++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared constants and the counter-width helper for the board clock/reset slice.
package board_pkg;

  localparam int unsigned CLKDIV_DEFAULT          = 6;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 10000;
  localparam int unsigned RESET_STRETCH_DEFAULT   = 1024;

  // Ceiling log2 of n, never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/board_clkrst_debounce.sv
// One button channel: 2-flop synchroniser, polarity normalisation, debounce counter,
// debounced level and a one-cycle press pulse.
module debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned       CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]     LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          sample;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{ACTIVE_LOW}};
    else        sync <= {sync[0], raw};
  end

  assign sample = sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample != level) begin
        if (cnt == LAST) begin
          level <= sample;
          cnt   <= '0;
          press <= sample;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/board_clkrst.sv
// Board clock divider, button debounce, stretched synchronous-release reset and trap LED.
// Optional macro TRAP_BLINK_EN makes the trap LED blink instead of holding steady.
module board_clkrst
  import board_pkg::*;
#(
  parameter int unsigned CLKDIV          = CLKDIV_DEFAULT,
  parameter int unsigned NBTN            = 2,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned RESET_BTN       = 0,
  parameter int unsigned RESET_STRETCH   = RESET_STRETCH_DEFAULT,
  parameter int unsigned BLINK_LOG2      = 22
) (
  input  logic            clk,
  input  logic            power_on_reset_n,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            trap,
  output logic            sysclk,
  output logic            sysclk_en,
  output logic            sys_reset,
  output logic [NBTN-1:0] btn,
  output logic [NBTN-1:0] btn_press,
  output logic            trap_led
);

  if (CLKDIV < 2 || CLKDIV > 65535) begin : g_bad_clkdiv
    $error("CLKDIV must be in 2..65535");
  end
  if (NBTN < 1 || RESET_BTN >= NBTN || DEBOUNCE_CYCLES < 1 || BLINK_LOG2 < 1) begin : g_bad_cfg
    $error("illegal button/debounce/blink configuration");
  end

  localparam int unsigned   DW       = cnt_width(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_FALL = DW'(CLKDIV / 2 - 1);

  localparam int unsigned   SW       = cnt_width(RESET_STRETCH + 1);
  localparam logic [SW-1:0] STR_LOAD = SW'(RESET_STRETCH);

  logic [DW-1:0] div_cnt;
  logic [SW-1:0] stretch_cnt;
  logic          rst_src;
  logic          trap_latched;

  // Divider: sysclk rises on the wrap to 0, falls when the count becomes CLKDIV/2.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      div_cnt <= '0;
      sysclk  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sysclk  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (div_cnt == DIV_FALL) sysclk <= 1'b0;
    end
  end

  assign sysclk_en = (div_cnt == DIV_LAST);

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk  (clk),
      .rst_n(power_on_reset_n),
      .raw  (btn_raw[i]),
      .level(btn[i]),
      .press(btn_press[i])
    );
  end

  assign rst_src = btn[RESET_BTN];

  // Power-on reset is itself a reset source, so the stretch counter resets loaded.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      stretch_cnt <= STR_LOAD;
      sys_reset   <= 1'b1;
    end else if (rst_src) begin
      stretch_cnt <= STR_LOAD;
      sys_reset   <= 1'b1;
    end else begin
      if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;
      if (sysclk_en && stretch_cnt == '0) sys_reset <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n)      trap_latched <= 1'b0;
    else if (sys_reset)         trap_latched <= 1'b0;
    else if (sysclk_en && trap) trap_latched <= 1'b1;
  end

`ifdef TRAP_BLINK_EN
  logic                  trap_set;
  logic [BLINK_LOG2-1:0] blink_cnt;

  assign trap_set = ~sys_reset & ~trap_latched & sysclk_en & trap;

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) blink_cnt <= '0;
    else if (trap_set)     blink_cnt <= '0;
    else                   blink_cnt <= blink_cnt + 1'b1;
  end

  assign trap_led = trap_latched & ~blink_cnt[BLINK_LOG2-1];
`else
  assign trap_led = trap_latched;
`endif

endmodule
